// File: rtl/jednostka_skokow.sv
// Jump/call-return unit: resolves JMP/JZ/JNZ/CALL/RET into a jump request for the
// program counter and keeps a hardware return-address stack with sticky error flags.
module jednostka_skokow #(
    parameter int AW    = 8,
    parameter int DEPTH = 8,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [AW-1:0] cel,
    input  logic [AW-1:0] pc,
    input  logic          flaga,
    input  logic          clr_bledu,
    output logic          jmp_en,
    output logic [AW-1:0] adres_skoku,
    output logic [DW-1:0] glebokosc,
    output logic          blad_przepelnienia,
    output logic          blad_niedomiaru
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_JMP  = 3'b001,
        OP_JZ   = 3'b010,
        OP_JNZ  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } op_t;

    logic [AW-1:0] stos [DEPTH];
    logic [DW-1:0] wsk;
    logic          blad_prz_q;
    logic          blad_nie_q;

    logic          pelny;
    logic          pusty;
    logic [PW-1:0] idx_push;
    logic [PW-1:0] idx_top;
    logic [AW-1:0] szczyt;

    logic          skok;
    logic [AW-1:0] adres;
    logic          push;
    logic          pop;
    logic          err_prz;
    logic          err_nie;

    assign pelny    = (wsk == DW'(DEPTH));
    assign pusty    = (wsk == '0);
    assign idx_push = PW'(wsk);
    // Top-of-stack index is only meaningful when the stack is non-empty.
    assign idx_top  = PW'(wsk - DW'(1));
    assign szczyt   = stos[idx_top];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        skok    = 1'b0;
        adres   = '0;
        push    = 1'b0;
        pop     = 1'b0;
        err_prz = 1'b0;
        err_nie = 1'b0;
        if (rst && en) begin
            case (op_t'(op))
                OP_JMP: begin
                    skok  = 1'b1;
                    adres = cel;
                end
                OP_JZ: begin
                    skok  = flaga;
                    adres = flaga ? cel : '0;
                end
                OP_JNZ: begin
                    skok  = !flaga;
                    adres = flaga ? '0 : cel;
                end
                OP_CALL: begin
                    if (pelny) begin
                        err_prz = 1'b1;
                    end else begin
                        skok  = 1'b1;
                        adres = cel;
                        push  = 1'b1;
                    end
                end
                OP_RET: begin
                    if (pusty) begin
                        err_nie = 1'b1;
                    end else begin
                        skok  = 1'b1;
                        adres = szczyt;
                        pop   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign jmp_en      = skok;
    assign adres_skoku = adres;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the stack array is reset as well, so a post-reset stack never holds old addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stos[i] <= '0;
            end
            wsk        <= '0;
            blad_prz_q <= 1'b0;
            blad_nie_q <= 1'b0;
        end else begin
            if (push) begin
                stos[idx_push] <= pc + AW'(1);
                wsk            <= wsk + DW'(1);
            end else if (pop) begin
                wsk <= wsk - DW'(1);
            end
            // A new error in the same cycle as a clear keeps the flag set.
            blad_prz_q <= err_prz | (blad_prz_q & !clr_bledu);
            blad_nie_q <= err_nie | (blad_nie_q & !clr_bledu);
        end
    end

    assign glebokosc          = wsk;
    assign blad_przepelnienia = blad_prz_q;
    assign blad_niedomiaru    = blad_nie_q;

endmodule

// File: tb/tb_jednostka_skokow.sv
// Randomized plus directed bench for jednostka_skokow against a queue-based
// reference model of the jump rules and return stack.
module tb_jednostka_skokow;

    localparam int AW    = 8;
    localparam int DEPTH = 8;
    localparam int DW    = 4;

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] cel;
    logic [AW-1:0] pc;
    logic          flaga;
    logic          clr_bledu;
    logic          jmp_en;
    logic [AW-1:0] adres_skoku;
    logic [DW-1:0] glebokosc;
    logic          blad_przepelnienia;
    logic          blad_niedomiaru;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW-1:0] m_stack[$];
    bit            m_ov;
    bit            m_un;

    jednostka_skokow #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .op                 (op),
        .cel                (cel),
        .pc                 (pc),
        .flaga              (flaga),
        .clr_bledu          (clr_bledu),
        .jmp_en             (jmp_en),
        .adres_skoku        (adres_skoku),
        .glebokosc          (glebokosc),
        .blad_przepelnienia (blad_przepelnienia),
        .blad_niedomiaru    (blad_niedomiaru)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a rising edge: drive one instruction, check the
    // combinational decision mid-cycle, then check state after the next edge.
    task automatic step(input logic e, input logic [2:0] o, input logic [AW-1:0] c,
                        input logic [AW-1:0] p, input logic f, input logic clr);
        bit            x_jmp;
        logic [AW-1:0] x_adr;
        bit            e_ov;
        bit            e_un;
        en = e; op = o; cel = c; pc = p; flaga = f; clr_bledu = clr;
        x_jmp = 0; x_adr = '0; e_ov = 0; e_un = 0;
        if (e) begin
            case (o)
                3'd1: begin x_jmp = 1; x_adr = c; end
                3'd2: if (f)  begin x_jmp = 1; x_adr = c; end
                3'd3: if (!f) begin x_jmp = 1; x_adr = c; end
                3'd4: begin
                    if (m_stack.size() < DEPTH) begin
                        x_jmp = 1; x_adr = c;
                        m_stack.push_back(AW'((int'(p) + 1) % 256));
                    end else e_ov = 1;
                end
                3'd5: begin
                    if (m_stack.size() > 0) begin
                        x_jmp = 1; x_adr = m_stack.pop_back();
                    end else e_un = 1;
                end
                default: ;
            endcase
        end
        #3;
        check("jmp_en", 32'(jmp_en), 32'(x_jmp));
        check("adres_skoku", 32'(adres_skoku), 32'(x_adr));
        m_ov = e_ov || (m_ov && !clr);
        m_un = e_un || (m_un && !clr);
        @(posedge clk); #1;
        check("glebokosc", 32'(glebokosc), 32'(m_stack.size()));
        check("blad_przepelnienia", 32'(blad_przepelnienia), 32'(m_ov));
        check("blad_niedomiaru", 32'(blad_niedomiaru), 32'(m_un));
    endtask

    // Asynchronous reset pulse, checked while it is held low.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        m_stack.delete();
        m_ov = 0;
        m_un = 0;
        check("rst_jmp_en", 32'(jmp_en), 32'd0);
        check("rst_adres", 32'(adres_skoku), 32'd0);
        check("rst_glebokosc", 32'(glebokosc), 32'd0);
        check("rst_bledy", {30'd0, blad_przepelnienia, blad_niedomiaru}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; op = 3'b001; cel = 8'h40; pc = 8'h00;
        flaga = 1'b0; clr_bledu = 1'b0;
        m_ov = 0; m_un = 0;

        // Reset with a pending JMP must suppress the jump.
        #3;
        check("rst_jmp_en", 32'(jmp_en), 32'd0);
        check("rst_adres", 32'(adres_skoku), 32'd0);
        check("rst_glebokosc", 32'(glebokosc), 32'd0);
        check("rst_bledy", {30'd0, blad_przepelnienia, blad_niedomiaru}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(1, 3'b001, 8'h40, 8'h00, 0, 0);
        check("jmp_after_rst", 32'(m_stack.size()), 32'd0);

        // Conditional jumps and idle cases
        step(1, 3'b010, 8'h20, 8'h01, 1, 0);
        step(1, 3'b010, 8'h20, 8'h02, 0, 0);
        step(1, 3'b011, 8'h20, 8'h03, 0, 0);
        step(1, 3'b011, 8'h20, 8'h04, 1, 0);
        step(0, 3'b001, 8'h55, 8'h05, 0, 0);
        step(1, 3'b110, 8'h55, 8'h05, 0, 0);
        step(1, 3'b111, 8'h55, 8'h05, 0, 0);

        // Nested call/return
        step(1, 3'b100, 8'h10, 8'h05, 0, 0);
        step(1, 3'b100, 8'h30, 8'h12, 0, 0);
        check("nest_depth", 32'(glebokosc), 32'd2);
        step(1, 3'b101, 8'h00, 8'h31, 0, 0);
        step(1, 3'b101, 8'h00, 8'h14, 0, 0);

        // Return address wraps at the top of the address space
        step(1, 3'b100, 8'h80, 8'hFF, 0, 0);
        step(1, 3'b101, 8'h00, 8'h81, 0, 0);

        // Overflow, then LIFO drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 3'b100, 8'(8'h90 + i), 8'(8'h10 * i + 3), 0, 0);
        check("full_depth", 32'(glebokosc), 32'(DEPTH));
        step(1, 3'b100, 8'hA0, 8'h77, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 3'b101, 8'h00, 8'h00, 0, 0);

        // Underflow, clear, and clear racing a new underflow
        step(1, 3'b101, 8'h00, 8'h00, 0, 0);
        step(1, 3'b000, 8'h00, 8'h00, 0, 1);
        step(1, 3'b101, 8'h00, 8'h00, 0, 0);
        step(1, 3'b101, 8'h00, 8'h00, 0, 1);

        // Randomized traffic biased toward CALL/RET to reach full and empty
        for (int n = 0; n < 600; n++) begin
            logic [2:0] o;
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)      o = 3'b100;
            else if (r < 70) o = 3'b101;
            else             o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0) do_reset();
            step(($urandom_range(0, 9) != 0), o, 8'($urandom), 8'($urandom),
                 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jednostka_skokow.md
Name: jednostka_skokow

Overview:
- Jump/call-return unit that drives the program counter's jump inputs (jmp_en, adres_skoku) from decoded control-flow instructions.
- Holds a hardware return-address stack of DEPTH entries and resolves unconditional jumps, conditional jumps on the zero flag, calls and returns.
- Sits between the instruction decoder and the program counter; the counter captures its outputs on the falling clk edge of the same cycle.

Parameters:
- AW, 8, program address width; matches the program counter width.
- DEPTH, 8, number of return-stack entries (>=2).
- DW, 4, width of glebokosc; must hold 0..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  instruction valid; when 0 the unit is idle.
- op  in  3  operation: 000 NOP, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110/111 NOP.
- cel  in  AW  jump/call target address.
- pc  in  AW  current program counter value.
- flaga  in  1  zero flag from the ALU (1 = last result zero).
- clr_bledu  in  1  synchronous clear of sticky error flags.
- jmp_en  out  1  jump request to the program counter.
- adres_skoku  out  AW  jump destination.
- glebokosc  out  DW  current stack occupancy, 0..DEPTH.
- blad_przepelnienia  out  1  sticky: CALL issued with stack full.
- blad_niedomiaru  out  1  sticky: RET issued with stack empty.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - Stack pointer is 0 and all stack entries are 0.
  - glebokosc=0, both error flags 0.
  - jmp_en and adres_skoku are forced to 0 while rst=0.
- Decision path is combinational (zero latency) from en, op, cel, flaga, the stack top and glebokosc. Stack and error state update on the rising clk edge.
- When jmp_en=0, adres_skoku=0 (deterministic, never stale).
- en=0, or op NOP/110/111: jmp_en=0, no state change.
- JMP: jmp_en=1, adres_skoku=cel.
- JZ: taken iff flaga=1. JNZ: taken iff flaga=0. Taken: jmp_en=1, adres_skoku=cel. Not taken: jmp_en=0.
- CALL with glebokosc<DEPTH:
  - jmp_en=1, adres_skoku=cel.
  - At the rising edge, push (pc+1) mod 2^AW, so pc=255 pushes 0.
  - glebokosc increments by 1.
- CALL with glebokosc=DEPTH:
  - jmp_en=0 (call not taken; the counter advances normally).
  - No push; blad_przepelnienia set.
- RET with glebokosc>0:
  - jmp_en=1, adres_skoku=top entry.
  - At the rising edge, pop; glebokosc decrements by 1.
- RET with glebokosc=0:
  - jmp_en=0, no pop; blad_niedomiaru set.
- Error flags stay set until clr_bledu=1 at a rising edge. If clr_bledu and a new error occur in the same cycle, the new error wins (flag stays 1).
- Popped entries are not cleared; only the pointer moves. Stack contents are not observable except through RET.
- The stack is LIFO only: no wrap of the stack pointer, and the stack pointer never exceeds DEPTH or goes below 0.
- Reset asserted mid-sequence discards all stack contents. The first RET after reset is an underflow.

Test Plan:
- Reset: drive rst=0 with op=001, en=1, cel=0x40 -> jmp_en=0, adres_skoku=0, glebokosc=0, both errors 0. Release rst; next cycle -> jmp_en=1, adres_skoku=0x40.
- Conditional jumps: op=010, cel=0x20, flaga=1 -> jmp_en=1, adres_skoku=0x20. Same with flaga=0 -> jmp_en=0, adres_skoku=0. op=011 with flaga=0 -> jmp_en=1.
- Nested call/return: CALL cel=0x10 at pc=0x05, then CALL cel=0x30 at pc=0x12 -> glebokosc=2. RET -> adres_skoku=0x13. RET -> adres_skoku=0x06, glebokosc=0.
- Wrap: CALL at pc=0xFF -> pushed 0x00; following RET -> jmp_en=1, adres_skoku=0x00.
- Overflow:
  - 8 CALLs fill the stack; glebokosc=8.
  - 9th CALL -> jmp_en=0, blad_przepelnienia=1, glebokosc stays 8.
  - 8 RETs return the addresses in reverse push order.
- Underflow/clear: RET on empty stack -> jmp_en=0, blad_niedomiaru=1. clr_bledu=1 at a rising edge -> flag 0. clr_bledu together with another empty RET -> flag remains 1.
